emu_scan_ctrl: RTL and testbench

EMU_SCAN_CTRL -- requirements
Module: emu_scan_ctrl

---
 rtl/emu_pkg.sv | 24 ++
 rtl/emu_scan_counter.sv | 28 ++
 rtl/emu_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_emu_scan_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emu_pkg.sv
// Shared definitions for the emulator scan controller: FSM states, command
// encodings and the scan word width.
package emu_pkg;

  localparam int SCAN_W = 64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_FF_SHIFT  = 3'd2,
    S_RAM_SHIFT = 3'd3,
    S_FIN       = 3'd4
  } scan_state_e;

  typedef enum logic {
    OP_SAVE = 1'b0,
    OP_LOAD = 1'b1
  } scan_op_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/emu_scan_counter.sv
// Word counter for the scan controller: counts handshakes and flags when the
// current word is the last one of the active chain.
module emu_scan_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] last_idx_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q;

  // Clear wins over increment so the final handshake of a chain leaves the
  // counter at zero, ready for the next chain.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign last_o = (count_q == last_idx_i);

endmodule

// File: rtl/emu_scan_ctrl.sv
// Scan controller: halts the emulated DUT and streams its flip-flop chain and
// then its RAM chain out to (save) or in from (load) the host, word by word.
module emu_scan_ctrl
  import emu_pkg::*;
#(
  parameter int FF_WORDS  = 4,
  parameter int RAM_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  output logic              odata_valid,
  input  logic              odata_ready,
  output logic [SCAN_W-1:0] odata,
  input  logic              idata_valid,
  output logic              idata_ready,
  input  logic [SCAN_W-1:0] idata,
  output logic              busy,
  output logic              done,
  output logic              emu_halt,
  output logic              ff_scan,
  output logic [SCAN_W-1:0] ff_sdi,
  input  logic [SCAN_W-1:0] ff_sdo,
  output logic              ram_scan,
  output logic              ram_dir,
  output logic [SCAN_W-1:0] ram_sdi,
  input  logic [SCAN_W-1:0] ram_sdo
);

  localparam int CW = $clog2(max_int(FF_WORDS, RAM_WORDS) + 1);
  localparam logic [CW-1:0] FF_LAST  = CW'(FF_WORDS - 1);
  localparam logic [CW-1:0] RAM_LAST = CW'((RAM_WORDS > 0) ? RAM_WORDS - 1 : 0);
  localparam bit HAS_RAM = (RAM_WORDS > 0);

  scan_state_e state_q;
  scan_op_e    op_q;
  logic        busy_q;
  logic        done_q;
  logic        cmd_ready_q;

  logic          hs;
  logic          cnt_last;
  logic [CW-1:0] cnt_limit;

  // Control FSM; busy/done/cmd_ready are registered alongside the state so
  // they change only on the clock edge that enters the matching state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SAVE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= scan_op_e'(cmd_op);
            state_q     <= S_SETTLE;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          state_q <= S_FF_SHIFT;
        end
        S_FF_SHIFT: begin
          if (hs && cnt_last) begin
            if (HAS_RAM) begin
              state_q <= S_RAM_SHIFT;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_RAM_SHIFT: begin
          if (hs && cnt_last) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          op_q        <= OP_SAVE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Scan enables follow the host handshake directly, so a stalled host
  // freezes the chain. Saving the FF chain feeds the head word back in as a
  // rotation, leaving the DUT state intact after a full pass.
  always_comb begin
    odata_valid = 1'b0;
    odata       = '0;
    idata_ready = 1'b0;
    ff_scan     = 1'b0;
    ff_sdi      = '0;
    ram_scan    = 1'b0;
    ram_dir     = 1'b0;
    ram_sdi     = '0;
    cnt_limit   = FF_LAST;
    case (state_q)
      S_FF_SHIFT: begin
        if (op_q == OP_SAVE) begin
          odata_valid = 1'b1;
          odata       = ff_sdo;
          ff_scan     = odata_ready;
          ff_sdi      = ff_sdo;
        end else begin
          idata_ready = 1'b1;
          ff_scan     = idata_valid;
          ff_sdi      = idata;
        end
      end
      S_RAM_SHIFT: begin
        cnt_limit = RAM_LAST;
        ram_dir   = (op_q == OP_LOAD);
        if (op_q == OP_SAVE) begin
          odata_valid = 1'b1;
          odata       = ram_sdo;
          ram_scan    = odata_ready;
        end else begin
          idata_ready = 1'b1;
          ram_scan    = idata_valid;
          ram_sdi     = idata;
        end
      end
      default: begin
      end
    endcase
  end

  assign hs = ff_scan | ram_scan;

  emu_scan_counter #(
    .WIDTH(CW)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (hs & cnt_last),
    .inc_i      (hs),
    .last_idx_i (cnt_limit),
    .last_o     (cnt_last)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = cmd_ready_q;
  assign emu_halt  = halt_req | busy_q;

endmodule

// File: tb/tb_emu_scan_ctrl.sv
// Directed bench for emu_scan_ctrl: one DUT with FF=4/RAM=2 words and one
// with FF=3/RAM=0, each wrapped in a behavioural scan-chain model.
module tb_emu_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic halt_req, cmd_valid, cmd_ready, cmd_op;
  logic odata_valid, odata_ready, idata_valid, idata_ready;
  logic [63:0] odata, idata;
  logic busy, done, emu_halt, ff_scan, ram_scan, ram_dir;
  logic [63:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo;

  logic n_halt_req, n_cmd_valid, n_cmd_ready, n_cmd_op;
  logic n_odata_valid, n_odata_ready, n_idata_valid, n_idata_ready;
  logic [63:0] n_odata, n_idata;
  logic n_busy, n_done, n_emu_halt, n_ff_scan, n_ram_scan, n_ram_dir;
  logic [63:0] n_ff_sdi, n_ff_sdo, n_ram_sdi;

  int checks = 0;
  int failures = 0;

  emu_scan_ctrl #(.FF_WORDS(4), .RAM_WORDS(2)) dut (
    .clk(clk), .rst(rst), .halt_req(halt_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .odata_valid(odata_valid), .odata_ready(odata_ready), .odata(odata),
    .idata_valid(idata_valid), .idata_ready(idata_ready), .idata(idata),
    .busy(busy), .done(done), .emu_halt(emu_halt),
    .ff_scan(ff_scan), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .ram_scan(ram_scan), .ram_dir(ram_dir), .ram_sdi(ram_sdi), .ram_sdo(ram_sdo)
  );

  emu_scan_ctrl #(.FF_WORDS(3), .RAM_WORDS(0)) dut0 (
    .clk(clk), .rst(rst), .halt_req(n_halt_req),
    .cmd_valid(n_cmd_valid), .cmd_ready(n_cmd_ready), .cmd_op(n_cmd_op),
    .odata_valid(n_odata_valid), .odata_ready(n_odata_ready), .odata(n_odata),
    .idata_valid(n_idata_valid), .idata_ready(n_idata_ready), .idata(n_idata),
    .busy(n_busy), .done(n_done), .emu_halt(n_emu_halt),
    .ff_scan(n_ff_scan), .ff_sdi(n_ff_sdi), .ff_sdo(n_ff_sdo),
    .ram_scan(n_ram_scan), .ram_dir(n_ram_dir), .ram_sdi(n_ram_sdi), .ram_sdo(64'h0)
  );

  // Chain models: head word is visible on sdo, a shift moves every word one
  // place toward the head and inserts sdi at the tail.
  logic preload = 1'b0;
  logic [63:0] pre_ff[4];
  logic [63:0] pre_ram[2];
  logic [63:0] pre_ff0[3];
  logic [63:0] ff_mem[4];
  logic [63:0] ram_mem[2];
  logic [63:0] ff0_mem[3];

  assign ff_sdo   = ff_mem[0];
  assign ram_sdo  = ram_mem[0];
  assign n_ff_sdo = ff0_mem[0];

  always @(posedge clk) begin
    if (preload) begin
      ff_mem  <= pre_ff;
      ram_mem <= pre_ram;
      ff0_mem <= pre_ff0;
    end else begin
      if (ff_scan) begin
        for (int i = 0; i < 3; i++) ff_mem[i] <= ff_mem[i+1];
        ff_mem[3] <= ff_sdi;
      end
      if (ram_scan) begin
        ram_mem[0] <= ram_mem[1];
        ram_mem[1] <= ram_sdi;
      end
      if (n_ff_scan) begin
        for (int i = 0; i < 2; i++) ff0_mem[i] <= ff0_mem[i+1];
        ff0_mem[2] <= n_ff_sdi;
      end
    end
  end

  logic [63:0] got_w[8];
  int got_n, got_done, stall_shift, settle_bad, dir_bad;

  task automatic do_preload();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic set_default_chains();
    for (int i = 0; i < 4; i++) pre_ff[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
    for (int i = 0; i < 2; i++) pre_ram[i] = 64'h5A5A_0000_0000_0010 + 64'(i);
    for (int i = 0; i < 3; i++) pre_ff0[i] = 64'hC3C3_0000_0000_0020 + 64'(i);
  endtask

  // Runs one save on the main DUT, collecting accepted words and cycle of done
  // (cycle 1 is the first cycle after the command handshake).
  task automatic run_save(input bit toggle);
    got_n = 0; got_done = -1; stall_shift = 0; settle_bad = 0; dir_bad = 0;
    for (int i = 0; i < 8; i++) got_w[i] = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; odata_ready = 1'b1; idata_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (toggle && c >= 2) odata_ready = (c % 2 == 0);
      #1;
      if (c == 1 && (ff_scan || ram_scan || odata_valid || !busy || !emu_halt)) settle_bad++;
      if (!odata_ready && (ff_scan || ram_scan)) stall_shift++;
      if (ram_scan && (ram_sdi != 64'h0 || ram_dir != 1'b0)) dir_bad++;
      if (odata_valid && odata_ready && got_n < 8) begin
        got_w[got_n] = odata;
        got_n++;
      end
      if (done) begin
        got_done = c;
        break;
      end
    end
    odata_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_cmd_ready: got %0h want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %0h want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done: got %0h want 0", done); end
    checks++; if (emu_halt !== 1'b0) begin failures++; $display("[TB] FAIL rst_emu_halt: got %0h want 0", emu_halt); end
    checks++; if ({odata_valid, idata_ready, ff_scan, ram_scan, ram_dir} !== 5'b0) begin failures++;
      $display("[TB] FAIL rst_outputs: got %b want 00000", {odata_valid, idata_ready, ff_scan, ram_scan, ram_dir}); end
    checks++; if (n_cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_n_cmd_ready: got %0h want 1", n_cmd_ready); end
    rst = 1'b0;
  endtask

  task automatic test_save();
    logic [63:0] exp_w[6];
    set_default_chains();
    do_preload();
    exp_w = '{64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002,
              64'hA5A5_0000_0000_0003, 64'h5A5A_0000_0000_0010, 64'h5A5A_0000_0000_0011};
    run_save(1'b0);
    checks++; if (settle_bad !== 0) begin failures++; $display("[TB] FAIL save_settle: got %0d bad want 0", settle_bad); end
    checks++; if (got_n !== 6) begin failures++; $display("[TB] FAIL save_count: got %0d want 6", got_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_w[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL save_word%0d: got %h want %h", i, got_w[i], exp_w[i]); end
    end
    checks++; if (got_done !== 8) begin failures++; $display("[TB] FAIL save_done_cycle: got %0d want 8", got_done); end
    checks++; if (dir_bad !== 0) begin failures++; $display("[TB] FAIL save_ram_dir_sdi: got %0d bad want 0", dir_bad); end
    @(negedge clk); #1;
    checks++; if ({done, busy, cmd_ready} !== 3'b001) begin failures++; $display("[TB] FAIL save_after: got %b want 001", {done, busy, cmd_ready}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ff_mem[i] !== exp_w[i]) begin failures++; $display("[TB] FAIL save_ff_kept%0d: got %h want %h", i, ff_mem[i], exp_w[i]); end
    end
  endtask

  task automatic test_load_then_save();
    int k, both, dir_bad_l, done_c;
    for (int i = 0; i < 4; i++) pre_ff[i] = '0;
    for (int i = 0; i < 2; i++) pre_ram[i] = '0;
    do_preload();
    k = 0; both = 0; dir_bad_l = 0; done_c = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; idata_valid = 1'b1; idata = 64'h1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      idata = 64'(k + 1);
      #1;
      if (odata_valid && idata_ready) both++;
      if (ram_scan && ram_dir !== 1'b1) dir_bad_l++;
      if (idata_ready && idata_valid) k++;
      if (done) begin done_c = c; break; end
    end
    idata_valid = 1'b0;
    checks++; if (k !== 6) begin failures++; $display("[TB] FAIL load_count: got %0d want 6", k); end
    checks++; if (done_c !== 8) begin failures++; $display("[TB] FAIL load_done_cycle: got %0d want 8", done_c); end
    checks++; if (both !== 0) begin failures++; $display("[TB] FAIL load_both_valid: got %0d want 0", both); end
    checks++; if (dir_bad_l !== 0) begin failures++; $display("[TB] FAIL load_ram_dir: got %0d bad want 0", dir_bad_l); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ff_mem[i] !== 64'(i + 1)) begin failures++; $display("[TB] FAIL load_ff%0d: got %h want %h", i, ff_mem[i], 64'(i + 1)); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (ram_mem[i] !== 64'(i + 5)) begin failures++; $display("[TB] FAIL load_ram%0d: got %h want %h", i, ram_mem[i], 64'(i + 5)); end
    end
    run_save(1'b0);
    checks++; if (got_n !== 6) begin failures++; $display("[TB] FAIL reload_count: got %0d want 6", got_n); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got_w[i] !== 64'(i + 1)) begin failures++; $display("[TB] FAIL reload_word%0d: got %h want %h", i, got_w[i], 64'(i + 1)); end
    end
  endtask

  task automatic test_stall();
    set_default_chains();
    do_preload();
    run_save(1'b1);
    checks++; if (stall_shift !== 0) begin failures++; $display("[TB] FAIL stall_shift: got %0d want 0", stall_shift); end
    checks++; if (got_n !== 6) begin failures++; $display("[TB] FAIL stall_count: got %0d want 6", got_n); end
    checks++; if (got_w[2] !== 64'hA5A5_0000_0000_0002) begin failures++; $display("[TB] FAIL stall_word2: got %h want a5a5000000000002", got_w[2]); end
    checks++; if (got_w[5] !== 64'h5A5A_0000_0000_0011) begin failures++; $display("[TB] FAIL stall_word5: got %h want 5a5a000000000011", got_w[5]); end
    checks++; if (got_done !== 13) begin failures++; $display("[TB] FAIL stall_done_cycle: got %0d want 13", got_done); end
    checks++; if (ff_mem[0] !== 64'hA5A5_0000_0000_0000) begin failures++; $display("[TB] FAIL stall_ff_kept: got %h want a5a5000000000000", ff_mem[0]); end
  endtask

  task automatic test_reset_midshift();
    set_default_chains();
    do_preload();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; odata_ready = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (ff_scan !== 1'b1) begin failures++; $display("[TB] FAIL mid_second_word: got %0h want 1", ff_scan); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; odata_ready = 1'b0; #1;
    checks++; if ({busy, cmd_ready} !== 2'b01) begin failures++; $display("[TB] FAIL mid_idle: got %b want 01", {busy, cmd_ready}); end
    checks++; if ({ff_scan, ram_scan, odata_valid, done, emu_halt} !== 5'b0) begin failures++;
      $display("[TB] FAIL mid_outputs: got %b want 00000", {ff_scan, ram_scan, odata_valid, done, emu_halt}); end
    run_save(1'b0);
    checks++; if (got_done !== 8) begin failures++; $display("[TB] FAIL mid_reissue_done: got %0d want 8", got_done); end
    checks++; if (got_w[0] !== 64'hA5A5_0000_0000_0002) begin failures++; $display("[TB] FAIL mid_reissue_word0: got %h want a5a5000000000002", got_w[0]); end
  endtask

  task automatic test_halt_busy();
    int rb, halt_bad, busy_cnt, done_c;
    @(negedge clk); halt_req = 1'b1; #1;
    checks++; if ({emu_halt, busy, cmd_ready} !== 3'b101) begin failures++; $display("[TB] FAIL halt_idle: got %b want 101", {emu_halt, busy, cmd_ready}); end
    @(negedge clk); halt_req = 1'b0; #1;
    checks++; if (emu_halt !== 1'b0) begin failures++; $display("[TB] FAIL halt_release: got %0h want 0", emu_halt); end
    rb = 0; halt_bad = 0; busy_cnt = 0; done_c = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; odata_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); #1;
      if (busy && cmd_ready) rb++;
      if (emu_halt !== 1'b1) halt_bad++;
      if (busy) busy_cnt++;
      if (done) begin done_c = c; break; end
    end
    @(negedge clk); cmd_valid = 1'b0; odata_ready = 1'b0; #1;
    checks++; if (rb !== 0) begin failures++; $display("[TB] FAIL busy_cmd_ready: got %0d want 0", rb); end
    checks++; if (halt_bad !== 0) begin failures++; $display("[TB] FAIL busy_emu_halt: got %0d bad want 0", halt_bad); end
    checks++; if (busy_cnt !== 8) begin failures++; $display("[TB] FAIL busy_cycles: got %0d want 8", busy_cnt); end
    checks++; if (done_c !== 8) begin failures++; $display("[TB] FAIL busy_single_op: got %0d want 8", done_c); end
    checks++; if ({busy, cmd_ready} !== 2'b01) begin failures++; $display("[TB] FAIL busy_back_idle: got %b want 01", {busy, cmd_ready}); end
  endtask

  task automatic test_no_ram();
    int n, ram_seen, last_c, done_c, other_bad;
    logic [63:0] w[3];
    set_default_chains();
    do_preload();
    n = 0; ram_seen = 0; last_c = -1; done_c = -1; other_bad = 0;
    for (int i = 0; i < 3; i++) w[i] = '0;
    @(negedge clk);
    n_cmd_valid = 1'b1; n_cmd_op = 1'b0; n_odata_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); n_cmd_valid = 1'b0; #1;
      if (n_ram_scan || n_ram_dir || n_ram_sdi != 64'h0) ram_seen++;
      if (n_idata_ready || !n_emu_halt || !n_busy || n_cmd_ready) other_bad++;
      if (n_odata_valid && n_odata_ready && n < 3) begin w[n] = n_odata; n++; last_c = c; end
      if (n_done) begin done_c = c; break; end
    end
    n_odata_ready = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("[TB] FAIL noram_count: got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (w[i] !== 64'hC3C3_0000_0000_0020 + 64'(i)) begin failures++;
        $display("[TB] FAIL noram_word%0d: got %h want %h", i, w[i], 64'hC3C3_0000_0000_0020 + 64'(i)); end
    end
    checks++; if (last_c !== 4) begin failures++; $display("[TB] FAIL noram_last_word_cycle: got %0d want 4", last_c); end
    checks++; if (done_c !== 5) begin failures++; $display("[TB] FAIL noram_done_cycle: got %0d want 5", done_c); end
    checks++; if (ram_seen !== 0) begin failures++; $display("[TB] FAIL noram_ram_active: got %0d want 0", ram_seen); end
    checks++; if (other_bad !== 0) begin failures++; $display("[TB] FAIL noram_status: got %0d bad want 0", other_bad); end
  endtask

  initial begin
    rst = 1'b1;
    halt_req = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    odata_ready = 1'b0; idata_valid = 1'b0; idata = '0;
    n_halt_req = 1'b0; n_cmd_valid = 1'b0; n_cmd_op = 1'b0;
    n_odata_ready = 1'b0; n_idata_valid = 1'b0; n_idata = '0;
    set_default_chains();
    test_reset();
    test_save();
    test_load_then_save();
    test_stall();
    test_reset_midshift();
    test_halt_busy();
    test_no_ram();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
